// File: rtl/lock_sequence_ctrl.sv
// lock_sequence_ctrl: control FSM for the door-lock/alarm datapath.
// Sequences the entry timer after the door opens, checks a 4-symbol keypad
// code, counts wrong codes and escalates to alarm.
// Optional build macro LOCK_AUTO_RELOCK_EN: relock automatically after
// RELOCK_CYCLES idle (door closed) cycles in UNLOCKED.
module lock_sequence_ctrl #(
    parameter logic [7:0] CODE          = 8'b10_01_11_00,
    parameter int         ENTRY_CYCLES  = 8,
    parameter int         DIGIT_TIMEOUT = 16,
    parameter int         MAX_TRIES     = 3,
    parameter int         RELOCK_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       anysw,
    input  logic       key_valid,
    input  logic [1:0] key_sym,
    input  logic       lock_cmd,
    output logic       locked,
    output logic       alarm,
    output logic       entimer,
    output logic [1:0] fail_cnt
);

    localparam int ET_W = $clog2(ENTRY_CYCLES);
    localparam int DT_W = $clog2(DIGIT_TIMEOUT);

    localparam logic [ET_W-1:0] ENTRY_LOAD = ET_W'(ENTRY_CYCLES - 1);
    localparam logic [DT_W-1:0] DIGIT_LOAD = DT_W'(DIGIT_TIMEOUT - 1);
    localparam logic [1:0]      MAX_FAIL   = 2'(MAX_TRIES);

    typedef enum logic [1:0] {
        S_LOCKED   = 2'd0,
        S_ENTRY    = 2'd1,
        S_UNLOCKED = 2'd2,
        S_ALARM    = 2'd3
    } state_t;

    state_t            state, next_state;
    logic [1:0]        idx;
    logic              mismatch;
    logic [ET_W-1:0]   entry_cnt;
    logic [DT_W-1:0]   digit_cnt;

    logic [1:0]        exp_sym;
    logic              key_take;
    logic              sym_miss;
    logic              code_done;
    logic              code_ok;
    logic              code_bad;
    logic [1:0]        fail_inc;
    logic              to_alarm;

`ifdef LOCK_AUTO_RELOCK_EN
    localparam int RL_W = $clog2(RELOCK_CYCLES);
    localparam logic [RL_W-1:0] RELOCK_LOAD = RL_W'(RELOCK_CYCLES - 1);
    logic [RL_W-1:0] relock_cnt;
`endif

    // Select the code symbol expected at the current entry position.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        exp_sym = CODE[7:6];
        case (idx)
            2'd0: exp_sym = CODE[7:6];
            2'd1: exp_sym = CODE[5:4];
            2'd2: exp_sym = CODE[3:2];
            2'd3: exp_sym = CODE[1:0];
            default: exp_sym = CODE[7:6];
        endcase
    end

    // Keys are only evaluated outside UNLOCKED; a code completes on the 4th symbol.
    assign key_take  = key_valid && (state != S_UNLOCKED);
    assign sym_miss  = (key_sym != exp_sym);
    assign code_done = key_take && (idx == 2'd3);
    assign code_ok   = code_done && !(mismatch || sym_miss);
    assign code_bad  = code_done && (mismatch || sym_miss);
    assign fail_inc  = (fail_cnt >= MAX_FAIL) ? MAX_FAIL : fail_cnt + 2'd1;
    assign to_alarm  = code_bad && (fail_inc == MAX_FAIL);

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) state <= S_LOCKED;
        else       state <= next_state;
    end

    // Next-state logic; a completing code always outranks the door sensor and timer.
    always_comb begin
        next_state = state;
        case (state)
            S_LOCKED: begin
                if (code_ok)                     next_state = S_UNLOCKED;
                else if (to_alarm)               next_state = S_ALARM;
                else if (anysw && !code_done)    next_state = S_ENTRY;
            end
            S_ENTRY: begin
                if (code_ok)                     next_state = S_UNLOCKED;
                else if (to_alarm || entry_cnt == '0) next_state = S_ALARM;
            end
            S_UNLOCKED: begin
                if (lock_cmd)                    next_state = S_LOCKED;
`ifdef LOCK_AUTO_RELOCK_EN
                else if (!anysw && relock_cnt == '0) next_state = S_LOCKED;
`endif
            end
            S_ALARM: begin
                if (code_ok)                     next_state = S_UNLOCKED;
            end
            default: next_state = S_LOCKED;
        endcase
    end

    // Output decode from the registered state.
    always_comb begin
        locked  = 1'b1;
        alarm   = 1'b0;
        entimer = 1'b0;
        case (state)
            S_ENTRY:    entimer = 1'b1;
            S_UNLOCKED: locked  = 1'b0;
            S_ALARM:    alarm   = 1'b1;
            default:    ;
        endcase
    end

    // Code checker: symbol index, sticky mismatch flag and inter-digit timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx       <= 2'd0;
            mismatch  <= 1'b0;
            digit_cnt <= '0;
        end else if (state == S_UNLOCKED) begin
            idx      <= 2'd0;
            mismatch <= 1'b0;
        end else if (key_take) begin
            digit_cnt <= DIGIT_LOAD;
            if (idx == 2'd3) begin
                idx      <= 2'd0;
                mismatch <= 1'b0;
            end else begin
                idx      <= idx + 2'd1;
                mismatch <= mismatch | sym_miss;
            end
        end else if (idx != 2'd0) begin
            if (digit_cnt == '0) begin
                idx      <= 2'd0;
                mismatch <= 1'b0;
            end else begin
                digit_cnt <= digit_cnt - DT_W'(1);
            end
        end
    end

    // Wrong-code counter, cleared by a correct code and saturating at MAX_TRIES.
    always_ff @(posedge clk) begin
        if (reset)         fail_cnt <= 2'd0;
        else if (code_ok)  fail_cnt <= 2'd0;
        else if (code_bad) fail_cnt <= fail_inc;
    end

    // Entry timer: loaded when the door opens in LOCKED, counts down in ENTRY.
    always_ff @(posedge clk) begin
        if (reset)
            entry_cnt <= '0;
        else if (state == S_LOCKED && next_state == S_ENTRY)
            entry_cnt <= ENTRY_LOAD;
        else if (state == S_ENTRY && entry_cnt != '0)
            entry_cnt <= entry_cnt - ET_W'(1);
    end

`ifdef LOCK_AUTO_RELOCK_EN
    // Relock counter: loaded on entry to UNLOCKED, held off while the door is open.
    always_ff @(posedge clk) begin
        if (reset)
            relock_cnt <= '0;
        else if (state != S_UNLOCKED && next_state == S_UNLOCKED)
            relock_cnt <= RELOCK_LOAD;
        else if (state == S_UNLOCKED) begin
            if (anysw)                relock_cnt <= RELOCK_LOAD;
            else if (relock_cnt != '0) relock_cnt <= relock_cnt - RL_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_lock_sequence_ctrl.sv
// tb_lock_sequence_ctrl: directed bench for lock_sequence_ctrl.
// Each stimulus step queues the output vector expected after the edge that
// samples it; a monitor pops and compares one entry per cycle.
// Build with +define+LOCK_AUTO_RELOCK_EN to include the auto-relock checks.
module tb_lock_sequence_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       anysw = 1'b0;
    logic       key_valid = 1'b0;
    logic [1:0] key_sym = 2'd0;
    logic       lock_cmd = 1'b0;
    logic       locked, alarm, entimer;
    logic [1:0] fail_cnt;

    int total = 0;
    int bad   = 0;

    // Expected vector layout: {locked, alarm, entimer, fail_cnt[1:0]}.
    localparam logic [4:0] EL0  = 5'b1_0_0_00;
    localparam logic [4:0] EL1  = 5'b1_0_0_01;
    localparam logic [4:0] EL2  = 5'b1_0_0_10;
    localparam logic [4:0] EEN  = 5'b1_0_1_00;
    localparam logic [4:0] EAL0 = 5'b1_1_0_00;
    localparam logic [4:0] EAL3 = 5'b1_1_0_11;
    localparam logic [4:0] EUN  = 5'b0_0_0_00;

    localparam logic [7:0] GOOD  = 8'b10_01_11_00;
    localparam logic [7:0] ZERO  = 8'b00_00_00_00;
    localparam logic [7:0] MISS1 = 8'b00_01_11_00;

    logic [4:0] exp_q[$];
    string      name_q[$];

    lock_sequence_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .anysw     (anysw),
        .key_valid (key_valid),
        .key_sym   (key_sym),
        .lock_cmd  (lock_cmd),
        .locked    (locked),
        .alarm     (alarm),
        .entimer   (entimer),
        .fail_cnt  (fail_cnt)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and queue the outputs expected after the sampling edge.
    task automatic step(input logic r, input logic a, input logic kv, input logic [1:0] s,
                        input logic lc, input logic [4:0] e, input string nm);
        @(posedge clk);
        #2;
        reset     = r;
        anysw     = a;
        key_valid = kv;
        key_sym   = s;
        lock_cmd  = lc;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic idle(input int n, input logic [4:0] e, input string nm);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, e, nm);
    endtask

    task automatic key(input logic [1:0] s, input logic [4:0] e, input string nm);
        step(1'b0, 1'b0, 1'b1, s, 1'b0, e, nm);
    endtask

    task automatic enter_code(input logic [7:0] c, input logic [4:0] e_mid,
                              input logic [4:0] e_last, input string nm);
        key(c[7:6], e_mid, {nm, "_k1"});
        key(c[5:4], e_mid, {nm, "_k2"});
        key(c[3:2], e_mid, {nm, "_k3"});
        key(c[1:0], e_last, {nm, "_k4"});
    endtask

    // Monitor: compare one queued expectation per cycle, just after the edge.
    initial begin
        logic [4:0] e;
        logic [4:0] got;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {locked, alarm, entimer, fail_cnt};
                total++;
                if (got !== e) begin
                    bad++;
                    $display("FAIL %s: got locked=%b alarm=%b entimer=%b fail_cnt=%0d, expected locked=%b alarm=%b entimer=%b fail_cnt=%0d",
                             nm, got[4], got[3], got[2], got[1:0], e[4], e[3], e[2], e[1:0]);
                end
            end
        end
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        // Reset and idle.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, EL0, "reset");
        idle(5, EL0, "reset_idle");

        // Door opens, no code: 8 cycles of entry timer, then alarm; correct code clears it.
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, EEN, "entry_start");
        idle(7, EEN, "entry_run");
        idle(1, EAL0, "entry_expire");
        enter_code(GOOD, EAL0, EUN, "alarm_unlock");
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, EL0, "relock_cmd");

        // lock_cmd ignored in LOCKED; door opens and the code is entered in time.
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, EL0, "lock_ignored");
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, EEN, "entry_start2");
        enter_code(GOOD, EEN, EUN, "entry_unlock");
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, EUN, "unlocked_anysw");
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, EL0, "relock_cmd2");

        // Only the first symbol wrong: still a wrong code.
        enter_code(MISS1, EL0, EL1, "first_sym_miss");
        enter_code(GOOD, EL1, EUN, "unlock_clears_fail");
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, EL0, "relock_cmd3");

        // Three wrong codes escalate to alarm; a fourth saturates.
        enter_code(ZERO, EL0, EL1, "wrong1");
        enter_code(ZERO, EL1, EL2, "wrong2");
        enter_code(ZERO, EL2, EAL3, "wrong3");
        enter_code(ZERO, EAL3, EAL3, "wrong4_sat");
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1, EAL3, "alarm_ignores_cmds");
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, EL0, "reset_in_alarm");

        // Digit timeout discards a partial entry after 16 idle cycles.
        key(2'd2, EL0, "partial_k1");
        key(2'd1, EL0, "partial_k2");
        idle(16, EL0, "digit_idle16");
        enter_code(8'b11_00_10_01, EL0, EL1, "after_timeout_wrong");
        key(2'd3, EL1, "tail_k1");
        key(2'd0, EL1, "tail_k2");
        idle(16, EL1, "tail_discard");
        // 15 idle cycles do not discard.
        key(2'd2, EL1, "keep_k1");
        key(2'd1, EL1, "keep_k2");
        idle(15, EL1, "digit_idle15");
        key(2'd3, EL1, "keep_k3");
        key(2'd0, EUN, "keep_k4_unlock");
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, EL0, "relock_cmd4");

        // Correct code completes on the cycle the entry timer reaches 0.
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, EEN, "entry_start3");
        idle(4, EEN, "entry_wait");
        enter_code(GOOD, EEN, EUN, "entry_last_cycle");
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, EL0, "relock_cmd5");

        // Reset mid-ENTRY aborts the timer.
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, EEN, "entry_start4");
        idle(2, EEN, "entry_run4");
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, EL0, "reset_in_entry");
        idle(10, EL0, "post_reset_idle");

`ifdef LOCK_AUTO_RELOCK_EN
        // Auto relock after 32 closed-door cycles; an open door holds it off.
        enter_code(GOOD, EL0, EUN, "auto_unlock");
        idle(31, EUN, "auto_wait");
        idle(1, EL0, "auto_relock");
        enter_code(GOOD, EL0, EUN, "auto_unlock2");
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0, EUN, "auto_door_open");
        idle(31, EUN, "auto_wait2");
        idle(1, EL0, "auto_relock2");
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
